lcd_cmd_seq: RTL

- Command sequencer that sits directly upstream of LCD_CTRL and drives its cmd/cmd_valid inputs.
- Buffers host commands in a small FIFO and drops illegal opcodes.
- Issues one command at a time, only while LCD_CTRL busy is low.
- After issuing a Write (opcode 0), blocks until LCD_CTRL pulses done, so a new image sequence never overlaps an IRB write-back.

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_cmd_fifo.sv | 53 +++++
 rtl/lcd_cmd_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD_CTRL command path: opcodes, sequencer states,
// image geometry.
package lcd_pkg;

  localparam int unsigned CMD_WRITE       = 0;
  localparam int unsigned CMD_SHIFT_UP    = 1;
  localparam int unsigned CMD_SHIFT_DOWN  = 2;
  localparam int unsigned CMD_SHIFT_LEFT  = 3;
  localparam int unsigned CMD_SHIFT_RIGHT = 4;
  localparam int unsigned CMD_AVERAGE     = 5;
  localparam int unsigned CMD_MIRROR_X    = 6;
  localparam int unsigned CMD_MIRROR_Y    = 7;
  localparam int unsigned CMD_MAX_LEGAL   = 7;

  localparam int unsigned IMG_N      = 8;
  localparam int unsigned IMG_PIXELS = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    GUARD     = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x CMD_W) with flush; DEPTH must be a power of two
// so the pointers wrap without compare logic.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CMD_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [CMD_W-1:0]         wdata_i,
  output logic [CMD_W-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Command sequencer feeding LCD_CTRL: queues host opcodes, drops illegal ones,
// issues one at a time while busy is low and blocks after a Write until done.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned HOLDOFF = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CMD_W-1:0]       host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   flush,
  input  logic                   busy,
  input  logic                   done,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt,
  output logic                   wait_done,
  output logic                   idle
);
  localparam int unsigned GW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CMD_W-1:0] MAX_LEGAL = CMD_W'(CMD_MAX_LEGAL);
  localparam logic [CMD_W-1:0] OP_WRITE  = CMD_W'(CMD_WRITE);

  seq_state_e       state_q, post_guard;
  logic [CMD_W-1:0] cmd_q, fifo_head;
  logic             cmd_valid_q;
  logic [GW-1:0]    guard_q;
  logic [7:0]       drop_q;
  logic             fifo_full, fifo_empty;
  logic             handshake, push, pop, drop;

  // A push coinciding with flush is discarded entirely, including the drop count.
  assign host_ready = ~fifo_full;
  assign handshake  = host_valid & host_ready & ~flush;
  assign push       = handshake & (host_cmd <= MAX_LEGAL);
  assign drop       = handshake & (host_cmd > MAX_LEGAL);
  assign pop        = (state_q == IDLE) & ~fifo_empty & ~busy & ~flush;

  always_comb post_guard = (cmd_q == OP_WRITE) ? WAIT_DONE : IDLE;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (host_cmd),
    .rdata_o (fifo_head),
    .count_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      guard_q     <= '0;
      drop_q      <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_q       <= fifo_head;
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          guard_q <= GW'(HOLDOFF);
          if (flush)             state_q <= IDLE;
          else if (HOLDOFF == 0) state_q <= post_guard;
          else                   state_q <= GUARD;
        end
        GUARD: begin
          // guard_q counts the remaining cycles including this one
          if (flush)                  state_q <= IDLE;
          else if (guard_q <= GW'(1)) state_q <= post_guard;
          else                        guard_q <= guard_q - 1'b1;
        end
        WAIT_DONE: begin
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign drop_cnt  = drop_q;
  assign wait_done = (state_q == WAIT_DONE);
  assign idle      = (state_q == IDLE) & fifo_empty;

endmodule
